// File: rtl/handshake_arb_pkg.sv
// Shared types, defaults and helpers for the round-robin handshake arbiter.
package handshake_arb_pkg;

  localparam int unsigned DEF_N         = 4;
  localparam int unsigned DEF_GNT_DELAY = 2;
  localparam int unsigned DEF_MAX_HOLD  = 0;
  localparam int unsigned MAX_N         = 16;
  localparam int unsigned MAX_IDW       = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // One-hot vector with bit idx set, sized for the largest supported N.
  function automatic logic [MAX_N-1:0] onehot_f(input logic [MAX_IDW-1:0] idx);
    return MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/handshake_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface handshake_arbiter_if
  import handshake_arb_pkg::*;
#(
  parameter int unsigned N = DEF_N
) ();

  localparam int unsigned IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout_err;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout_err
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output timeout_err
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin search: first set request at ptr+1, ptr+2, ... with wrap mod N.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  // One extra bit so ptr+offset never overflows before the explicit wrap.
  localparam int unsigned PW = IDW + 1;

  logic [PW-1:0] pos;

  // Scan the N candidate positions in priority order; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      pos = {1'b0, ptr} + PW'(off);
      if (pos >= PW'(N)) begin
        pos = pos - PW'(N);
      end
      if (!found && req[pos[IDW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/handshake_arbiter.sv
// Round-robin owner sequencing for a shared delayed-grant handshake resource.
module handshake_arbiter
  import handshake_arb_pkg::*;
#(
  parameter int unsigned N         = DEF_N,
  parameter int unsigned GNT_DELAY = DEF_GNT_DELAY,
  parameter int unsigned MAX_HOLD  = DEF_MAX_HOLD
) (
  input  logic                clk,
  input  logic                rst,
  handshake_arbiter_if.slave  bus
);

  localparam int unsigned IDW       = $clog2(N);
  localparam int unsigned DLYW      = $clog2(GNT_DELAY + 1);
  localparam int unsigned HOLDW_RAW = $clog2(MAX_HOLD + 1);
  localparam int unsigned HOLDW     = (HOLDW_RAW < 1) ? 1 : HOLDW_RAW;

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   winner_q, winner_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [DLYW-1:0]  dly_q, dly_d;
  logic [HOLDW-1:0] hold_q, hold_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic             terr_q, terr_d;

  logic             pick_found;
  logic [IDW-1:0]   pick_idx;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State, counters and output registers; reset clears grants without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      winner_q <= '0;
      ptr_q    <= IDW'(N - 1);
      dly_q    <= '0;
      hold_q   <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      dly_q    <= dly_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
    end
  end

  // Next-state, counter and output decode for IDLE/WAIT/GRANT/RELEASE.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    ptr_d    = ptr_q;
    dly_d    = dly_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    terr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          winner_d = pick_idx;
          dly_d    = DLYW'(GNT_DELAY - 1);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (!bus.req[winner_q]) begin
          state_d = IDLE;
        end else if (dly_q == '0) begin
          state_d  = GRANT;
          gnt_d    = N'(onehot_f(MAX_IDW'(winner_q)));
          gnt_id_d = winner_q;
          hold_d   = '0;
        end else begin
          dly_d = dly_q - DLYW'(1);
        end
      end
      GRANT: begin
        if (!bus.req[winner_q]) begin
          gnt_d    = '0;
          gnt_id_d = '0;
          ptr_d    = winner_q;
          state_d  = RELEASE;
        end else if ((MAX_HOLD != 0) && (hold_q == HOLDW'(MAX_HOLD - 1))) begin
          gnt_d    = '0;
          gnt_id_d = '0;
          terr_d   = 1'b1;
          ptr_d    = winner_q;
          state_d  = RELEASE;
        end else begin
          hold_d = hold_q + HOLDW'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_id      = gnt_id_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule
